// File: rtl/dbg_av_write_buffer_pkg.sv
// Shared types, default window constants and the window-decode helper for the
// debug Avalon-MM posted-write buffer.
package dbg_av_write_buffer_pkg;

  // Default buffer geometry and accepted address window.
  localparam int unsigned DbgWbufDepth = 4;
  localparam logic [15:0] DbgWbufBase  = 16'h0000;
  localparam logic [15:0] DbgWbufSpan  = 16'h1000;

  // One buffered write: rebased address in the upper half, data in the lower.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wbuf_entry_t;

  // 17-bit compare so BASE+SPAN may reach 17'h10000 without wrapping.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] span);
    logic [16:0] a;
    logic [16:0] lo;
    logic [16:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, span};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a register-array store, wrapping pointers and an
// occupancy counter.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i, wdata_i    : write strobe and data (ignored when full)
//   pop_i, rdata_o     : read strobe (ignored when empty) and head entry
//   full_o, empty_o    : decoded from the occupancy counter
//   level_o            : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullLevel = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FullLevel);
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dbg_av_write_buffer.sv
// Posted-write buffer on the debug Avalon-MM master port. Single-word writes
// inside [BASE, BASE+SPAN) are rebased and queued; writes outside the window
// are accepted and discarded so the master never stalls on a bad address.
//   sysclk, sysreset                     : clock, synchronous active-high reset
//   av_address/writedata/write           : Avalon write request
//   av_waitrequest                       : backpressure, high while FIFO full
//   mem_addr/mem_data/mem_valid/mem_ready: drained write port (head entry)
//   level                                : FIFO occupancy
//   drop_count                           : saturating count of discarded writes
module dbg_av_write_buffer
  import dbg_av_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DbgWbufDepth,
  parameter logic [15:0] BASE  = DbgWbufBase,
  parameter logic [15:0] SPAN  = DbgWbufSpan
) (
  input  logic                   sysclk,
  input  logic                   sysreset,
  input  logic [15:0]            av_address,
  input  logic [15:0]            av_writedata,
  input  logic                   av_write,
  output logic                   av_waitrequest,
  output logic [15:0]            mem_addr,
  output logic [15:0]            mem_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_count
);

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        win_hit;
  logic        push;
  logic        pop;
  wbuf_entry_t push_entry;
  wbuf_entry_t head_entry;
  logic [7:0]  drop_count_q, drop_count_d;

  // Waitrequest ignores the address: a full FIFO stalls every write.
  assign av_waitrequest = fifo_full;
  assign mem_valid      = !fifo_empty;

  assign accept  = av_write && !av_waitrequest;
  assign win_hit = in_window(av_address, BASE, SPAN);
  assign push    = accept && win_hit;
  assign pop     = mem_valid && mem_ready;

  // Cannot underflow: only used when the window test has passed.
  assign push_entry.addr = av_address - BASE;
  assign push_entry.data = av_writedata;

  assign mem_addr = head_entry.addr;
  assign mem_data = head_entry.data;

  always_comb begin
    drop_count_d = drop_count_q;
    if (accept && !win_hit && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) drop_count_q <= 8'h00;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;

  sync_fifo #(
    .WIDTH ($bits(wbuf_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (sysclk),
    .rst_i   (sysreset),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

endmodule

// File: tb/tb_dbg_av_write_buffer.sv
// Directed bench for dbg_av_write_buffer: instance A uses the default window
// (BASE=0, SPAN=0x1000), instance B a narrow window at 0x8000.
module tb_dbg_av_write_buffer;
  import dbg_av_write_buffer_pkg::*;

  localparam int unsigned Depth = DbgWbufDepth;

  logic        sysclk;
  logic        sysreset;

  logic [15:0] av_address_a, av_writedata_a, mem_addr_a, mem_data_a;
  logic        av_write_a, wait_a, mem_valid_a, mem_ready_a;
  logic [$clog2(Depth):0] level_a;
  logic [7:0]  drop_a;

  logic [15:0] av_address_b, av_writedata_b, mem_addr_b, mem_data_b;
  logic        av_write_b, wait_b, mem_valid_b, mem_ready_b;
  logic [$clog2(Depth):0] level_b;
  logic [7:0]  drop_b;

  int checks = 0;
  int errors = 0;

  dbg_av_write_buffer #(
    .DEPTH (Depth),
    .BASE  (16'h0000),
    .SPAN  (16'h1000)
  ) u_dut_a (
    .sysclk         (sysclk),
    .sysreset       (sysreset),
    .av_address     (av_address_a),
    .av_writedata   (av_writedata_a),
    .av_write       (av_write_a),
    .av_waitrequest (wait_a),
    .mem_addr       (mem_addr_a),
    .mem_data       (mem_data_a),
    .mem_valid      (mem_valid_a),
    .mem_ready      (mem_ready_a),
    .level          (level_a),
    .drop_count     (drop_a)
  );

  dbg_av_write_buffer #(
    .DEPTH (Depth),
    .BASE  (16'h8000),
    .SPAN  (16'h0100)
  ) u_dut_b (
    .sysclk         (sysclk),
    .sysreset       (sysreset),
    .av_address     (av_address_b),
    .av_writedata   (av_writedata_b),
    .av_write       (av_write_b),
    .av_waitrequest (wait_b),
    .mem_addr       (mem_addr_b),
    .mem_data       (mem_data_b),
    .mem_valid      (mem_valid_b),
    .mem_ready      (mem_ready_b),
    .level          (level_b),
    .drop_count     (drop_b)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [15:0] addr, input logic [15:0] data);
    av_write_a     = 1'b1;
    av_address_a   = addr;
    av_writedata_a = data;
  endtask

  task automatic wr_b(input logic [15:0] addr, input logic [15:0] data);
    av_write_b     = 1'b1;
    av_address_b   = addr;
    av_writedata_b = data;
  endtask

  logic [31:0] q [$];
  int          drop_model;
  int          sz;
  logic        inwin;
  logic        saw_wait;

  initial begin
    sysreset = 1'b1;
    av_write_a = 1'b0; av_address_a = '0; av_writedata_a = '0; mem_ready_a = 1'b0;
    av_write_b = 1'b0; av_address_b = '0; av_writedata_b = '0; mem_ready_b = 1'b0;
    step();
    step();
    sysreset = 1'b0;

    // Reset state
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_valid", 32'(mem_valid_a), 32'd0);
    chk("rst_wait", 32'(wait_a), 32'd0);
    chk("rst_drop", 32'(drop_a), 32'd0);

    // Single write, ready high: visible next cycle, popped the cycle after
    mem_ready_a = 1'b1;
    wr_a(16'h0010, 16'hBEEF);
    step();
    av_write_a = 1'b0;
    chk("t1_valid", 32'(mem_valid_a), 32'd1);
    chk("t1_addr", 32'(mem_addr_a), 32'h0010);
    chk("t1_data", 32'(mem_data_a), 32'hBEEF);
    chk("t1_level", 32'(level_a), 32'd1);
    step();
    chk("t1_valid_after", 32'(mem_valid_a), 32'd0);
    chk("t1_level_after", 32'(level_a), 32'd0);

    // Fill to full, stall the 5th write, release with one pop
    mem_ready_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_a(16'(i), 16'hA000 + 16'(i));
      step();
    end
    chk("t2_level_full", 32'(level_a), 32'd4);
    chk("t2_wait_full", 32'(wait_a), 32'd1);
    wr_a(16'd5, 16'hA005);
    step();
    chk("t2_level_stall", 32'(level_a), 32'd4);
    chk("t2_head1_addr", 32'(mem_addr_a), 32'd1);
    chk("t2_head1_data", 32'(mem_data_a), 32'hA001);
    mem_ready_a = 1'b1;
    step();
    mem_ready_a = 1'b0;
    chk("t2_level_pop", 32'(level_a), 32'd3);
    chk("t2_wait_drop", 32'(wait_a), 32'd0);
    step();
    av_write_a = 1'b0;
    chk("t2_level_5th", 32'(level_a), 32'd4);
    chk("t2_wait_5th", 32'(wait_a), 32'd1);
    mem_ready_a = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("t2_drain_addr", 32'(mem_addr_a), 32'(k));
      chk("t2_drain_data", 32'(mem_data_a), 32'hA000 + 32'(k));
      step();
    end
    chk("t2_level_empty", 32'(level_a), 32'd0);

    // Window edges on instance B
    wr_b(16'h7FFF, 16'h0001); step();
    wr_b(16'h8000, 16'h0002); step();
    wr_b(16'h80FF, 16'h0003); step();
    wr_b(16'h8100, 16'h0004); step();
    av_write_b = 1'b0;
    chk("t3_level", 32'(level_b), 32'd2);
    chk("t3_drop", 32'(drop_b), 32'd2);
    chk("t3_head0_addr", 32'(mem_addr_b), 32'h0000);
    chk("t3_head0_data", 32'(mem_data_b), 32'h0002);
    mem_ready_b = 1'b1;
    step();
    chk("t3_head1_addr", 32'(mem_addr_b), 32'h00FF);
    chk("t3_head1_data", 32'(mem_data_b), 32'h0003);
    step();
    chk("t3_level_empty", 32'(level_b), 32'd0);

    // 260 out-of-window writes: drop_count saturates, no backpressure
    saw_wait = 1'b0;
    wr_b(16'h0000, 16'h1234);
    for (int i = 1; i <= 260; i++) begin
      step();
      if (wait_b) saw_wait = 1'b1;
      if (i == 252) chk("t4_drop_fe", 32'(drop_b), 32'hFE);
    end
    av_write_b = 1'b0;
    chk("t4_drop_sat", 32'(drop_b), 32'hFF);
    chk("t4_no_wait", 32'(saw_wait), 32'd0);
    chk("t4_level", 32'(level_b), 32'd0);

    // Random stream on instance A against a queue model
    drop_model = 0;
    av_write_a = 1'b0;
    inwin = 1'b1;
    for (int i = 0; i < 600; i++) begin
      sz = q.size();
      chk("t5_level", 32'(level_a), 32'(sz));
      chk("t5_valid", 32'(mem_valid_a), 32'(sz != 0));
      chk("t5_wait", 32'(wait_a), 32'(sz == Depth));
      if (sz != 0) chk("t5_head", {mem_addr_a, mem_data_a}, q[0]);
      // Avalon rule: hold the request while stalled
      if (!(av_write_a && sz == Depth)) begin
        av_write_a = ($urandom_range(0, 3) != 0);
        inwin = ($urandom_range(0, 3) != 0);
        av_address_a = inwin ? 16'($urandom_range(0, 16'h0FFF))
                             : 16'($urandom_range(16'h1000, 16'hFFFF));
        av_writedata_a = 16'($urandom);
      end
      mem_ready_a = ($urandom_range(0, 1) != 0);
      if (sz != 0 && mem_ready_a) void'(q.pop_front());
      if (av_write_a && sz != Depth) begin
        if (inwin) q.push_back({av_address_a, av_writedata_a});
        else if (drop_model < 255) drop_model++;
      end
      step();
    end
    av_write_a = 1'b0;
    chk("t5_drop", 32'(drop_a), 32'(drop_model));
    mem_ready_a = 1'b1;
    while (q.size() != 0) begin
      chk("t5_tail_head", {mem_addr_a, mem_data_a}, q[0]);
      void'(q.pop_front());
      step();
    end
    chk("t5_final_level", 32'(level_a), 32'd0);

    // Reset with entries buffered and a write in flight
    mem_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_a(16'h0040 + 16'(i), 16'h5500 + 16'(i));
      step();
    end
    chk("t6_level_pre", 32'(level_a), 32'd3);
    wr_a(16'h0050, 16'h6600);
    sysreset = 1'b1;
    step();
    sysreset = 1'b0;
    av_write_a = 1'b0;
    chk("t6_level", 32'(level_a), 32'd0);
    chk("t6_valid", 32'(mem_valid_a), 32'd0);
    chk("t6_wait", 32'(wait_a), 32'd0);
    chk("t6_drop", 32'(drop_a), 32'd0);
    mem_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_stale", 32'(mem_valid_a), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_av_write_buffer.md
# dbg_av_write_buffer

Posted-write buffer on the debug Avalon-MM master port of the supervised Synapse316. It accepts single-word writes from the visor's `dbg_av_*` master and filters them against a decoded window. In-window writes are queued in a small FIFO and drained to a simple valid/ready write port on program RAM or a peripheral. Out-of-window writes are accepted and discarded, so the visor never stalls on a bad address.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Power of 2, 2..16.
- `BASE`, 16'h0000: first address of the accepted window.
- `SPAN`, 16'h1000: window size in words. Nonzero. `BASE+SPAN` must be ≤ 17'h10000.

Ports:
- `sysclk`, in, 1: the only clock.
- `sysreset`, in, 1: synchronous, active-high reset.
- `av_address`, in, 16: Avalon write address, from `dbg_av_address`.
- `av_writedata`, in, 16: Avalon write data.
- `av_write`, in, 1: Avalon write request.
- `av_waitrequest`, out, 1: Avalon backpressure.
- `mem_addr`, out, 16: drained write address, relative (`av_address - BASE`).
- `mem_data`, out, 16: drained write data.
- `mem_valid`, out, 1: head entry present.
- `mem_ready`, in, 1: sink takes the head this cycle.
- `level`, out, log2(DEPTH)+1: current occupancy.
- `drop_count`, out, 8: out-of-window writes discarded. Saturates at 8'hFF.

## Operation
- Accept: a write is accepted on a cycle where `av_write && !av_waitrequest`.
- In-window test: `BASE <= av_address < BASE+SPAN`, computed with 17-bit compare so nothing wraps.
- In-window accept: push `{av_address-BASE, av_writedata}`. The subtraction is 16-bit and cannot underflow because the window test has already passed.
- Out-of-window accept: no push. `drop_count` increments unless it is already at FF.
- `av_waitrequest = full`, decoded from registered `level == DEPTH`. It is asserted even for out-of-window writes, because the range is not checked against waitrequest.
- Drain: a pop happens when `mem_valid && mem_ready`. `mem_valid = (level != 0)`. `mem_addr` and `mem_data` show the head entry and stay stable while `mem_valid && !mem_ready`.
- Simultaneous push and pop when not empty: `level` is unchanged. Both pointers advance, both modulo DEPTH, with natural wrap.
- Push into empty with `mem_ready` high: there is no bypass. The entry appears on `mem_*` next cycle and pops the cycle after.
- Pop when full: `av_waitrequest` falls the next cycle. The stalled master's write is accepted then.
- Reset: `level`=0, pointers=0, `drop_count`=0, `mem_valid`=0, `av_waitrequest`=0. `mem_addr`/`mem_data` are don't-care while `mem_valid`=0. Buffered entries are discarded. An in-flight `av_write` during the reset cycle is ignored.
- `av_write` deasserted: the `av_address` and `av_writedata` inputs are ignored.

## Timing
- Accept edge N → `mem_valid` high from cycle N+1, if the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: one accept and one drain per cycle. With `mem_ready` held high the FIFO never fills.
- `level` and `drop_count` update on the edge of the accept or pop, and are visible the following cycle.
- All outputs are registered or decoded from registers. There is no combinational path from `av_*` or `mem_ready` to any output.
- `av_waitrequest` follows the Avalon rule. The master holds `av_address`, `av_writedata` and `av_write` stable while it is high.

## Structure
- `` `define DBG_WBUF_DEPTH `` and the default window constants go in `header.v`, next to `` `DEBUG_PEEK_REG ``, so the top level and the bench share them.
- One sub-module, `sync_fifo`. It is parameterised by WIDTH and DEPTH, has push/pop/full/empty/level, and uses a RAM array with wrap pointers plus a count register.
- `dbg_av_write_buffer` adds the window decode, the address rebase and the drop counter around `sync_fifo` (WIDTH=32).

## Test plan
- After reset, write 16'h0010 ← 16'hBEEF with BASE=0 and `mem_ready`=1 → the next cycle shows `mem_valid`=1, `mem_addr`=16'h0010, `mem_data`=16'hBEEF. It pops the following cycle and `level` returns to 0.
- With `mem_ready`=0, do 5 back-to-back writes at DEPTH=4 → writes 1–4 are accepted and `av_waitrequest`=1 with `level`=4. Raise `mem_ready` for one cycle → the 5th write is accepted the next cycle, and drain order is 1,2,3,4,5.
- With BASE=16'h8000 and SPAN=16'h0100, write addresses 16'h7FFF, 16'h8000, 16'h80FF and 16'h8100 → only the 8000 and 80FF writes emerge, as `mem_addr` 16'h0000 and 16'h00FF. `drop_count`=2.
- Do 260 out-of-window writes → `drop_count` saturates at 8'hFF, and `av_waitrequest` never rises.
- Run a long random stream with random `mem_ready` (over 3×DEPTH pointer wraps) → the output sequence equals the in-window input sequence, and `level` never exceeds DEPTH.
- Assert `sysreset` for one cycle with `level`=3 and `av_write` high → on the next cycle `level`=0, `mem_valid`=0, `av_waitrequest`=0, `drop_count`=0, and nothing stale drains afterwards.
